// File: rtl/datapath_regs_hs.sv
// rtl/datapath_regs_hs.sv - ACC/PC/MBR/MAR/IR datapath with encoded transfers and req/ack memory bus
module datapath_regs_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [11:0]              i_ctrl,
  input  logic                     i_mem_rd,
  input  logic                     i_mem_wr,
  input  logic                     i_ctrl_halt,
  input  logic                     i_err_clr,
  output logic                     o_busy,
  output logic                     o_mem_err,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  input  logic                     i_mem_ack,
  output logic [DATA_W-ADDR_W-1:0] o_ir_opcode,
  output logic [DATA_W-1:0]        o_alu_p,
  output logic [DATA_W-1:0]        o_alu_q,
  input  logic [DATA_W-1:0]        i_alu_br,
  input  logic [DATA_W-1:0]        i_alu_mr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d, mbr_q, mbr_d, ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic                ctrl_en;
  logic                req_act;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mbr_q   <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      mar_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mbr_q   <= mbr_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign ctrl_en = (state_q == S_IDLE) && !i_ctrl_halt;

  // Each destination picks one source by fixed priority; all sources are pre-edge values.
  always_comb begin
    acc_d   = acc_q;
    mbr_d   = mbr_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    state_d = state_q;
    tcnt_d  = tcnt_q;

    if (ctrl_en) begin
      if (i_ctrl[0])       mar_d = pc_q;
      else if (i_ctrl[1])  mar_d = mbr_q[ADDR_W-1:0];
      else if (i_ctrl[11]) mar_d = mar_q + ADDR_W'(1);

      if (i_ctrl[7])       mbr_d = acc_q;
      else if (i_ctrl[5])  mbr_d = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      else if (i_ctrl[2])  mbr_d = {{(DATA_W-ADDR_W){1'b0}}, pc_q};

      if (i_ctrl[3])       pc_d = mbr_q[ADDR_W-1:0];
      else if (i_ctrl[10]) pc_d = pc_q + ADDR_W'(1);

      if (i_ctrl[4])       ir_d = mbr_q;

      if (i_ctrl[6])       acc_d = mbr_q;
      else if (i_ctrl[8])  acc_d = i_alu_br;
      else if (i_ctrl[9])  acc_d = i_alu_mr;
    end

    case (state_q)
      S_IDLE: begin
        if (!i_ctrl_halt) begin
          if (i_mem_rd) begin
            state_d = S_RD;
            tcnt_d  = '0;
          end else if (i_mem_wr) begin
            state_d = S_WR;
            tcnt_d  = '0;
          end
        end
      end
      S_RD, S_WR: begin
        if (i_ctrl_halt) begin
          state_d = S_IDLE;
        end else if (i_mem_ack) begin
          state_d = S_IDLE;
          if (state_q == S_RD) mbr_d = i_mem_rdata;
        end else if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        if (i_err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Halt masks the bus and opcode combinationally so the CU sees them drop in the same cycle.
  assign req_act     = ((state_q == S_RD) || (state_q == S_WR)) && !i_ctrl_halt;
  assign o_busy      = (state_q != S_IDLE);
  assign o_mem_err   = (state_q == S_ERR);
  assign o_mem_req   = req_act;
  assign o_mem_we    = req_act && (state_q == S_WR);
  assign o_mem_addr  = req_act ? mar_q : '0;
  assign o_mem_wdata = (req_act && (state_q == S_WR)) ? mbr_q : '0;
  assign o_ir_opcode = i_ctrl_halt ? '0 : ir_q[DATA_W-1:ADDR_W];
  assign o_alu_p     = acc_q;
  assign o_alu_q     = mbr_q;

endmodule

// File: tb/tb_datapath_regs_hs.sv
// tb/tb_datapath_regs_hs.sv - directed self-checking bench for datapath_regs_hs
module tb_datapath_regs_hs;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [11:0]       i_ctrl = '0;
  logic              i_mem_rd = 1'b0;
  logic              i_mem_wr = 1'b0;
  logic              i_ctrl_halt = 1'b0;
  logic              i_err_clr = 1'b0;
  logic              o_busy, o_mem_err, o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata = '0;
  logic              i_mem_ack = 1'b0;
  logic [DATA_W-ADDR_W-1:0] o_ir_opcode;
  logic [DATA_W-1:0] o_alu_p, o_alu_q;
  logic [DATA_W-1:0] i_alu_br = '0;
  logic [DATA_W-1:0] i_alu_mr = '0;

  int passed = 0;
  int total  = 0;

  datapath_regs_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ctrl(i_ctrl), .i_mem_rd(i_mem_rd),
    .i_mem_wr(i_mem_wr), .i_ctrl_halt(i_ctrl_halt), .i_err_clr(i_err_clr),
    .o_busy(o_busy), .o_mem_err(o_mem_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack), .o_ir_opcode(o_ir_opcode), .o_alu_p(o_alu_p),
    .o_alu_q(o_alu_q), .i_alu_br(i_alu_br), .i_alu_mr(i_alu_mr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_ctrl(input logic [11:0] c);
    i_ctrl = c;
    tick();
    i_ctrl = '0;
  endtask

  task automatic load_acc(input logic [DATA_W-1:0] v);
    i_alu_br = v;
    do_ctrl(12'h100);
  endtask

  task automatic load_mbr(input logic [DATA_W-1:0] v);
    load_acc(v);
    do_ctrl(12'h080);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    total++; if ({o_busy, o_mem_err, o_mem_req, o_mem_we} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {o_busy, o_mem_err, o_mem_req, o_mem_we}); else passed++;
    total++; if ({o_mem_addr, o_mem_wdata, o_ir_opcode} !== '0) $display("FAIL reset_bus got %h exp 0", {o_mem_addr, o_mem_wdata, o_ir_opcode}); else passed++;
    total++; if ({o_alu_p, o_alu_q} !== '0) $display("FAIL reset_regs got %h exp 0", {o_alu_p, o_alu_q}); else passed++;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int busy_cnt = 0;
    int addr_bad = 0;
    load_mbr(16'h0005);
    do_ctrl(12'h008);
    do_ctrl(12'h001);
    i_mem_rd = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    total++; if ({o_mem_req, o_mem_we, o_mem_wdata} !== {1'b1, 1'b0, 16'h0}) $display("FAIL fetch_req got req=%b we=%b wd=%h exp 1 0 0000", o_mem_req, o_mem_we, o_mem_wdata); else passed++;
    for (int n = 1; n <= 20 && o_busy; n++) begin
      busy_cnt++;
      if (o_mem_addr !== 8'h05) addr_bad++;
      i_mem_ack   = (n == 3);
      i_mem_rdata = (n == 3) ? 16'h1234 : 16'h0;
      tick();
    end
    i_mem_ack = 1'b0;
    total++; if (addr_bad != 0) $display("FAIL fetch_addr got %0d bad cycles exp 0", addr_bad); else passed++;
    total++; if (busy_cnt != 3) $display("FAIL fetch_busy got %0d exp 3", busy_cnt); else passed++;
    total++; if (o_alu_q !== 16'h1234) $display("FAIL fetch_mbr got %h exp 1234", o_alu_q); else passed++;
    do_ctrl(12'h010);
    total++; if (o_ir_opcode !== 8'h12) $display("FAIL fetch_opcode got %h exp 12", o_ir_opcode); else passed++;
  endtask

  task automatic test_write();
    int busy_cnt = 0;
    load_mbr(16'h0040);
    do_ctrl(12'h002);
    load_mbr(16'hBEEF);
    i_mem_wr = 1'b1;
    tick();
    i_mem_wr = 1'b0;
    total++; if ({o_mem_req, o_mem_we} !== 2'b11) $display("FAIL write_req got %b exp 11", {o_mem_req, o_mem_we}); else passed++;
    total++; if (o_mem_wdata !== 16'hBEEF) $display("FAIL write_wdata got %h exp beef", o_mem_wdata); else passed++;
    total++; if (o_mem_addr !== 8'h40) $display("FAIL write_addr got %h exp 40", o_mem_addr); else passed++;
    for (int n = 1; n <= 20 && o_busy; n++) begin
      busy_cnt++;
      i_mem_ack = 1'b1;
      tick();
    end
    i_mem_ack = 1'b0;
    total++; if (busy_cnt != 1) $display("FAIL write_busy got %0d exp 1", busy_cnt); else passed++;
    total++; if ({o_mem_req, o_mem_we, o_mem_wdata} !== '0) $display("FAIL write_idle got req=%b we=%b wd=%h exp 0", o_mem_req, o_mem_we, o_mem_wdata); else passed++;
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    i_mem_rd = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!o_mem_req) break;
      req_cnt++;
      tick();
    end
    total++; if (req_cnt != 15) $display("FAIL timeout_cycles got %0d exp 15", req_cnt); else passed++;
    total++; if ({o_mem_err, o_mem_req, o_busy} !== 3'b101) $display("FAIL timeout_err got err=%b req=%b busy=%b exp 1 0 1", o_mem_err, o_mem_req, o_busy); else passed++;
    total++; if (o_alu_q !== 16'hBEEF) $display("FAIL timeout_mbr got %h exp beef", o_alu_q); else passed++;
    i_alu_mr = 16'h5555;
    i_mem_rd = 1'b1;
    do_ctrl(12'h200);
    i_mem_rd = 1'b0;
    total++; if ({o_alu_p, o_mem_err, o_mem_req} !== {16'hBEEF, 1'b1, 1'b0}) $display("FAIL err_ignore got acc=%h err=%b req=%b exp beef 1 0", o_alu_p, o_mem_err, o_mem_req); else passed++;
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    total++; if ({o_mem_err, o_busy} !== 2'b00) $display("FAIL err_clr got err=%b busy=%b exp 0 0", o_mem_err, o_busy); else passed++;
  endtask

  task automatic test_wrap_priority();
    load_mbr(16'h00FF);
    do_ctrl(12'h008);
    do_ctrl(12'h400);
    do_ctrl(12'h004);
    total++; if (o_alu_q !== 16'h0000) $display("FAIL pc_wrap got %h exp 0000", o_alu_q); else passed++;
    load_mbr(16'h00FF);
    do_ctrl(12'h002);
    load_mbr(16'h0033);
    do_ctrl(12'h802);
    i_mem_rd = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    total++; if (o_mem_addr !== 8'h33) $display("FAIL mar_prio got %h exp 33", o_mem_addr); else passed++;
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'h0033;
    tick();
    i_mem_ack = 1'b0;
    load_mbr(16'h00FF);
    do_ctrl(12'h002);
    do_ctrl(12'h800);
    i_mem_rd = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    total++; if (o_mem_addr !== 8'h00) $display("FAIL mar_wrap got %h exp 00", o_mem_addr); else passed++;
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'h0000;
    tick();
    i_mem_ack = 1'b0;
    load_mbr(16'h0010);
    do_ctrl(12'h008);
    load_mbr(16'h0020);
    do_ctrl(12'h00C);
    total++; if (o_alu_q !== 16'h0010) $display("FAIL swap_mbr got %h exp 0010", o_alu_q); else passed++;
    do_ctrl(12'h004);
    total++; if (o_alu_q !== 16'h0020) $display("FAIL swap_pc got %h exp 0020", o_alu_q); else passed++;
    i_alu_br = 16'h1111;
    i_alu_mr = 16'h2222;
    do_ctrl(12'h300);
    total++; if (o_alu_p !== 16'h1111) $display("FAIL acc_prio89 got %h exp 1111", o_alu_p); else passed++;
    i_alu_br = 16'h3333;
    do_ctrl(12'h140);
    total++; if (o_alu_p !== 16'h0020) $display("FAIL acc_prio68 got %h exp 0020", o_alu_p); else passed++;
    load_acc(16'hA5A5);
    do_ctrl(12'h084);
    total++; if (o_alu_q !== 16'hA5A5) $display("FAIL mbr_prio72 got %h exp a5a5", o_alu_q); else passed++;
  endtask

  task automatic test_simultaneous();
    load_mbr(16'h2222);
    load_acc(16'h1111);
    i_mem_rd = 1'b1;
    i_mem_wr = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
    total++; if ({o_mem_req, o_mem_we} !== 2'b10) $display("FAIL rd_wins got req=%b we=%b exp 1 0", o_mem_req, o_mem_we); else passed++;
    i_ctrl = 12'h040;
    tick();
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'h7777;
    tick();
    i_mem_ack = 1'b0;
    i_ctrl = '0;
    total++; if (o_alu_p !== 16'h1111) $display("FAIL stall_acc got %h exp 1111", o_alu_p); else passed++;
    total++; if ({o_alu_q, o_busy} !== {16'h7777, 1'b0}) $display("FAIL stall_mbr got %h busy=%b exp 7777 0", o_alu_q, o_busy); else passed++;
  endtask

  task automatic test_halt_reset();
    i_mem_rd = 1'b1;
    tick();
    i_mem_rd = 1'b0;
    total++; if ({o_mem_req, o_ir_opcode} !== {1'b1, 8'h12}) $display("FAIL halt_pre got req=%b op=%h exp 1 12", o_mem_req, o_ir_opcode); else passed++;
    i_ctrl_halt = 1'b1;
    #1;
    total++; if ({o_mem_req, o_mem_we, o_mem_addr, o_ir_opcode} !== '0) $display("FAIL halt_gate got req=%b we=%b addr=%h op=%h exp 0", o_mem_req, o_mem_we, o_mem_addr, o_ir_opcode); else passed++;
    i_mem_ack = 1'b1;
    i_mem_rdata = 16'hAAAA;
    tick();
    i_mem_ack = 1'b0;
    total++; if ({o_busy, o_alu_q} !== {1'b0, 16'h7777}) $display("FAIL halt_abort got busy=%b mbr=%h exp 0 7777", o_busy, o_alu_q); else passed++;
    i_alu_br = 16'h9999;
    i_mem_rd = 1'b1;
    do_ctrl(12'h100);
    i_mem_rd = 1'b0;
    total++; if ({o_busy, o_alu_p} !== {1'b0, 16'h1111}) $display("FAIL halt_ignore got busy=%b acc=%h exp 0 1111", o_busy, o_alu_p); else passed++;
    i_ctrl_halt = 1'b0;
    #1;
    total++; if (o_ir_opcode !== 8'h12) $display("FAIL halt_release got %h exp 12", o_ir_opcode); else passed++;
    i_mem_wr = 1'b1;
    tick();
    i_mem_wr = 1'b0;
    total++; if ({o_mem_req, o_mem_we} !== 2'b11) $display("FAIL rst_pre got %b exp 11", {o_mem_req, o_mem_we}); else passed++;
    i_rst_n = 1'b0;
    #1;
    total++; if ({o_busy, o_mem_err, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== '0) $display("FAIL rst_bus got busy=%b req=%b we=%b addr=%h wd=%h exp 0", o_busy, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata); else passed++;
    total++; if ({o_ir_opcode, o_alu_p, o_alu_q} !== '0) $display("FAIL rst_regs got op=%h p=%h q=%h exp 0", o_ir_opcode, o_alu_p, o_alu_q); else passed++;
    tick();
    i_rst_n = 1'b1;
    tick();
    total++; if (o_busy !== 1'b0) $display("FAIL rst_idle got %b exp 0", o_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_timeout();
    test_wrap_priority();
    test_simultaneous();
    test_halt_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
